// File: rtl/led_pattern_pkg.sv
// Shared types for the multi-channel LED pattern controller.
// Optional breathe mode is enabled by defining LED_BREATHE_EN.
package led_pattern_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF     = 3'd0,
    LED_ON      = 3'd1,
    LED_BLINK   = 3'd2,
    LED_PWM     = 3'd3,
    LED_BREATHE = 3'd4
  } led_mode_e;

  typedef enum logic {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, period counter, blink and optional breathe
// state (LED_BREATHE_EN), and the registered LED drive.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned DEF_PERIOD = 2000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [DUTY_W-1:0] pwm_ph_i,
  output logic              led_o,
  output logic              wrap_o
);

  led_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              blink_q, blink_d;
  logic              led_q, led_d;
  logic              wrap_q, wrap_d;
  logic              at_end;
  logic              breathe_on;

  always_comb begin
    at_end   = (cnt_q == period_q);
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = at_end ? '0 : cnt_q + CNT_W'(1);
    blink_d  = at_end ? ~blink_q : blink_q;
    wrap_d   = at_end;
    // A load restarts the period, so a coincident wrap is swallowed.
    if (load_i) begin
      mode_d   = led_mode_e'(mode_i);
      period_d = period_i;
      duty_d   = duty_i;
      cnt_d    = '0;
      blink_d  = 1'b0;
      wrap_d   = 1'b0;
    end
    case (mode_q)
      LED_OFF:     led_d = 1'b0;
      LED_ON:      led_d = 1'b1;
      LED_BLINK:   led_d = blink_q;
      LED_PWM:     led_d = (pwm_ph_i < duty_q);
      LED_BREATHE: led_d = breathe_on;
      default:     led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q   <= LED_OFF;
      period_q <= CNT_W'(DEF_PERIOD);
      duty_q   <= '0;
      cnt_q    <= '0;
      blink_q  <= 1'b0;
      led_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      led_q    <= led_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef LED_BREATHE_EN
  logic [DUTY_W-1:0] bduty_q, bduty_d;
  logic              bdown_q, bdown_d;

  // Triangle ramp: one step per wrap, turning around at full scale and zero.
  always_comb begin
    bduty_d = bduty_q;
    bdown_d = bdown_q;
    if (load_i) begin
      bduty_d = '0;
      bdown_d = 1'b0;
    end else if (at_end) begin
      if (!bdown_q) begin
        bduty_d = bduty_q + DUTY_W'(1);
        if (bduty_d == '1) bdown_d = 1'b1;
      end else begin
        bduty_d = bduty_q - DUTY_W'(1);
        if (bduty_d == '0) bdown_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bduty_q <= '0;
      bdown_q <= 1'b0;
    end else begin
      bduty_q <= bduty_d;
      bdown_q <= bdown_d;
    end
  end

  assign breathe_on = (pwm_ph_i < bduty_q);
`else
  assign breathe_on = 1'b0;
`endif

  assign led_o  = led_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: config handshake FSM, shared PWM phase and NUM_CH
// led_channel instances. Breathe mode is built only with LED_BREATHE_EN.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned DEF_PERIOD = 2000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [MODE_W-1:0]         cfg_mode,
  input  logic [CNT_W-1:0]          cfg_period,
  input  logic [DUTY_W-1:0]         cfg_duty,
  output logic [NUM_CH-1:0]         led_out,
  output logic [NUM_CH-1:0]         wrap_pulse
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  cfg_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] pwm_ph_q;
  logic              accept;
  logic              apply;

  // cfg_ready is registered so it stays low through the reset cycle itself.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    apply    = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_valid && ready_q) begin
          accept  = 1'b1;
          state_d = CFG_APPLY;
        end
      end
      CFG_APPLY: begin
        apply   = 1'b1;
        state_d = CFG_IDLE;
      end
      default: state_d = CFG_IDLE;
    endcase
    ready_d  = (state_d == CFG_IDLE);
    ch_d     = accept ? cfg_ch     : ch_q;
    mode_d   = accept ? cfg_mode   : mode_q;
    period_d = accept ? cfg_period : period_q;
    duty_d   = accept ? cfg_duty   : duty_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CFG_IDLE;
      ready_q  <= 1'b0;
      ch_q     <= '0;
      mode_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      pwm_ph_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      ch_q     <= ch_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      pwm_ph_q <= pwm_ph_q + DUTY_W'(1);
    end
  end

  assign cfg_ready = ready_q;

  // Out-of-range channel numbers match no instance, so the write is a no-op.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_channel #(
      .CNT_W      (CNT_W),
      .DUTY_W     (DUTY_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .load_i   (apply && (ch_q == CH_W'(g))),
      .mode_i   (mode_q),
      .period_i (period_q),
      .duty_i   (duty_q),
      .pwm_ph_i (pwm_ph_q),
      .led_o    (led_out[g]),
      .wrap_o   (wrap_pulse[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: vector table for reset/first write,
// then hand-written blink, PWM, handshake, reset and breathe sequences.
module tb_led_pattern_ctrl;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned DUTY_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch = '0;
  logic [2:0]        cfg_mode = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [DUTY_W-1:0] cfg_duty = '0;
  logic [NUM_CH-1:0] led_out;
  logic [NUM_CH-1:0] wrap_pulse;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  ph_m    = '0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DUTY_W     (DUTY_W),
    .DEF_PERIOD (2000000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .led_out    (led_out),
    .wrap_pulse (wrap_pulse)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  ch;
    logic [2:0]  mode;
    logic [23:0] period;
    logic [7:0]  duty;
    logic        exp_ready;
    logic [2:0]  exp_led;
    logic [2:0]  exp_wrap;
  } vec_t;

  vec_t vecs[11];

  // One posedge passes; returns at the following negedge. ph_m tracks pwm_ph.
  task automatic cyc();
    @(negedge clk);
    ph_m = rst_n ? ph_m + 8'd1 : 8'd0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [2:0] mode,
                           input logic [23:0] per, input logic [7:0] duty);
    int unsigned waited = 0;
    while (cfg_ready !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    check("wr_ready", {31'b0, cfg_ready}, 32'd1);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_duty   = duty;
    cyc();
    cfg_valid  = 1'b0;
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned hi;
    logic [2:0] exp_l;
    logic [2:0] exp_w;
    logic [1:0] b2b_ch[3];
    logic [2:0] b2b_mode[3];
    logic       b2b_rdy[6];

    //            rst   vld   ch    mode  period  duty   rdy   led     wrap
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b0, 3'b000, 3'b000};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b0, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 3'd2, 24'd4, 8'd0, 1'b0, 3'b000, 3'b000};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b1, 3'b000, 3'b010};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 3'd0, 24'd0, 8'd0, 1'b1, 3'b010, 3'b000};

    for (int i = 0; i < 11; i++) begin
      rst_n      = vecs[i].rst;
      cfg_valid  = vecs[i].valid;
      cfg_ch     = vecs[i].ch;
      cfg_mode   = vecs[i].mode;
      cfg_period = vecs[i].period;
      cfg_duty   = vecs[i].duty;
      cyc();
      check($sformatf("vec%0d_ready", i), {31'b0, cfg_ready}, {31'b0, vecs[i].exp_ready});
      check($sformatf("vec%0d_led", i), {29'b0, led_out}, {29'b0, vecs[i].exp_led});
      check($sformatf("vec%0d_wrap", i), {29'b0, wrap_pulse}, {29'b0, vecs[i].exp_wrap});
    end

    // ch1 blink, period 4: wrap every 5th cycle, LED lags blink by one cycle.
    for (int k = 7; k <= 25; k++) begin
      cyc();
      exp_w = (k % 5 == 0) ? 3'b010 : 3'b000;
      exp_l = (((k - 1) / 5) % 2 == 1) ? 3'b010 : 3'b000;
      check($sformatf("blink_led_k%0d", k), {29'b0, led_out}, {29'b0, exp_l});
      check($sformatf("blink_wrap_k%0d", k), {29'b0, wrap_pulse}, {29'b0, exp_w});
    end

    // PWM duty sweep on ch0: count high cycles over one full phase period.
    cfg_write(2'd0, 3'd3, 24'd1000, 8'd64);
    cyc();
    hi = 0;
    for (int k = 0; k < 256; k++) begin cyc(); if (led_out[0]) hi++; end
    check("pwm_duty64", hi, 32'd64);
    cfg_write(2'd0, 3'd3, 24'd1000, 8'd0);
    cyc();
    hi = 0;
    for (int k = 0; k < 256; k++) begin cyc(); if (led_out[0]) hi++; end
    check("pwm_duty0", hi, 32'd0);
    cfg_write(2'd0, 3'd3, 24'd1000, 8'd255);
    cyc();
    hi = 0;
    for (int k = 0; k < 256; k++) begin cyc(); if (led_out[0]) hi++; end
    check("pwm_duty255", hi, 32'd255);

    // Back-to-back writes with cfg_valid held high.
    b2b_ch   = '{2'd0, 2'd2, 2'd1};
    b2b_mode = '{3'd1, 3'd1, 3'd0};
    b2b_rdy  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    check("b2b_ready_start", {31'b0, cfg_ready}, 32'd1);
    cfg_valid  = 1'b1;
    cfg_ch     = b2b_ch[0];
    cfg_mode   = b2b_mode[0];
    cfg_period = 24'd1000;
    cfg_duty   = 8'd0;
    for (int s = 0; s < 6; s++) begin
      cyc();
      check($sformatf("b2b_ready_s%0d", s), {31'b0, cfg_ready}, {31'b0, b2b_rdy[s]});
      if (s == 1) begin cfg_ch = b2b_ch[1]; cfg_mode = b2b_mode[1]; end
      if (s == 3) begin cfg_ch = b2b_ch[2]; cfg_mode = b2b_mode[2]; end
      if (s == 4) cfg_valid = 1'b0;
    end
    cyc();
    check("b2b_led", {29'b0, led_out}, 32'b101);

    // Out-of-range channel: handshake completes, nothing changes.
    cfg_write(2'd3, 3'd0, 24'd5, 8'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check($sformatf("badch_led_k%0d", k), {29'b0, led_out}, 32'b101);
      check($sformatf("badch_wrap_k%0d", k), {29'b0, wrap_pulse}, 32'b000);
    end

    // One-cycle reset in the middle of a ch2 blink period.
    cfg_write(2'd2, 3'd2, 24'd10, 8'd0);
    for (int k = 0; k < 15; k++) cyc();
    rst_n = 1'b0;
    cyc();
    check("rst_mid_led", {29'b0, led_out}, 32'b000);
    check("rst_mid_wrap", {29'b0, wrap_pulse}, 32'b000);
    check("rst_mid_ready", {31'b0, cfg_ready}, 32'd0);
    rst_n = 1'b1;
    cyc();
    check("rst_rel_ready", {31'b0, cfg_ready}, 32'd1);
    for (int k = 0; k < 30; k++) begin
      cyc();
      check($sformatf("rst_quiet_k%0d", k), {26'b0, led_out, wrap_pulse}, 32'd0);
    end

    // Reset during APPLY drops the write.
    check("rst_apply_ready", {31'b0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_mode  = 3'd1;
    cyc();
    cfg_valid = 1'b0;
    rst_n     = 1'b0;
    cyc();
    check("rst_apply_ready0", {31'b0, cfg_ready}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("rst_apply_led_k%0d", k), {29'b0, led_out}, 32'b000);
    end

    // Breathe on ch2 with period 0.
    cfg_write(2'd2, 3'd4, 24'd0, 8'd0);
`ifdef LED_BREATHE_EN
    begin
      logic [7:0] bd;
      logic       dn;
      logic [7:0] ph_prev;
      int unsigned bad;
      bd = '0; dn = 1'b0; ph_prev = ph_m; bad = 0;
      for (int k = 1; k <= 520; k++) begin
        cyc();
        if (led_out[2] !== (ph_prev < bd)) bad++;
        if (!dn) begin bd = bd + 8'd1; if (bd == 8'd255) dn = 1'b1; end
        else     begin bd = bd - 8'd1; if (bd == 8'd0)   dn = 1'b0; end
        ph_prev = ph_m;
      end
      check("breathe_bad_cycles", bad, 32'd0);
    end
`else
    for (int k = 0; k < 40; k++) begin
      cyc();
      check($sformatf("breathe_off_k%0d", k), {31'b0, led_out[2]}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
